// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the MEM-stage access controller: access sizes, FSM states,
// and the alignment predicate used when MEM_MISALIGN_EXC_EN is defined.
package mem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    SZ_W  = 3'b000,
    SZ_H  = 3'b001,
    SZ_HU = 3'b010,
    SZ_B  = 3'b011,
    SZ_BU = 3'b100
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  // Unknown size codes behave as word accesses.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_B, SZ_BU: mis = 1'b0;
      SZ_H, SZ_HU: mis = addr_lo[0];
      default:     mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store data replication plus byte enables, and
// load byte/half extraction with sign or zero extension.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_size,
  input  logic [31:0] i_st_data,
  input  logic [31:0] i_ld_raw,
  output logic [31:0] o_st_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store side: replicate the narrow datum into every lane, enable only the addressed ones.
  always_comb begin
    o_st_data = i_st_data;
    o_be      = 4'b1111;
    case (i_size)
      SZ_B, SZ_BU: begin
        o_st_data = {4{i_st_data[7:0]}};
        o_be      = 4'b0001 << i_addr_lo;
      end
      SZ_H, SZ_HU: begin
        o_st_data = {2{i_st_data[15:0]}};
        o_be      = i_addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        o_st_data = i_st_data;
        o_be      = 4'b1111;
      end
    endcase
  end

  // Load side: pick the addressed lane, then extend to 32 bits.
  always_comb begin
    w_byte = i_ld_raw[7:0];
    case (i_addr_lo)
      2'b00:   w_byte = i_ld_raw[7:0];
      2'b01:   w_byte = i_ld_raw[15:8];
      2'b10:   w_byte = i_ld_raw[23:16];
      2'b11:   w_byte = i_ld_raw[31:24];
      default: w_byte = i_ld_raw[7:0];
    endcase
    if (i_addr_lo[1]) begin
      w_half = i_ld_raw[31:16];
    end else begin
      w_half = i_ld_raw[15:0];
    end
    case (i_size)
      SZ_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
      SZ_BU:   o_ld_data = {24'h000000, w_byte};
      SZ_H:    o_ld_data = {{16{w_half[15]}}, w_half};
      SZ_HU:   o_ld_data = {16'h0000, w_half};
      default: o_ld_data = i_ld_raw;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: req/ack bus master with pipeline stall,
// timeout abort, and optional misalignment exception (macro MEM_MISALIGN_EXC_EN).
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_we,
  input  logic        i_mem_rd,
  input  logic [2:0]  i_mem_size,
  output logic        o_stall,
  output logic        o_dm_req,
  output logic        o_dm_we,
  output logic [31:0] o_dm_addr,
  output logic [31:0] o_dm_wdata,
  output logic [3:0]  o_dm_be,
  input  logic [31:0] i_dm_rdata,
  input  logic        i_dm_ack,
  output logic [31:0] o_mem_result,
  output logic        o_bus_err,
  output logic        o_misalign
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_lbuf;
  logic               r_dm_req;
  logic               r_dm_we;
  logic [31:0]        r_dm_addr;
  logic [31:0]        r_dm_wdata;
  logic [3:0]         r_dm_be;
  logic               r_bus_err;
  logic               r_misalign;
  logic               r_mis_abort;

  logic               w_access;
  logic               w_is_load;
  logic               w_mis;
  logic               w_timeout;
  logic [31:0]        w_st_data;
  logic [3:0]         w_be;
  logic [31:0]        w_ld_data;

  // Inputs are held stable by the stall, so one aligner serves both capture and load return.
  mem_lane_align u_align (
    .i_addr_lo (i_mem_addr[1:0]),
    .i_size    (i_mem_size),
    .i_st_data (i_mem_data),
    .i_ld_raw  (i_dm_rdata),
    .o_st_data (w_st_data),
    .o_be      (w_be),
    .o_ld_data (w_ld_data)
  );

  assign w_access  = i_mem_rd | i_mem_we;
  assign w_is_load = i_mem_rd & ~i_mem_we;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

`ifdef MEM_MISALIGN_EXC_EN
  assign w_mis = w_access & is_misaligned(i_mem_size, i_mem_addr[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  // Next-state and stall decode.
  always_comb begin
    w_state_nxt = r_state;
    o_stall     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access) begin
          o_stall     = 1'b1;
          w_state_nxt = w_mis ? DONE : BUSY;
        end else begin
          o_stall     = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        o_stall = 1'b1;
        if (i_dm_ack || w_timeout) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = BUSY;
        end
      end
      DONE: begin
        o_stall     = 1'b0;
        w_state_nxt = IDLE;
      end
      default: begin
        o_stall     = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Result mux toward MEM/WB: load buffer only during the completing cycle of a load.
  always_comb begin
    if (r_state == DONE) begin
      if (r_mis_abort) begin
        o_mem_result = 32'h0000_0000;
      end else if (w_is_load) begin
        o_mem_result = r_lbuf;
      end else begin
        o_mem_result = i_mem_addr;
      end
    end else begin
      o_mem_result = i_mem_addr;
    end
  end

  // State, bus master registers, timeout counter and status pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_lbuf      <= 32'h0000_0000;
      r_dm_req    <= 1'b0;
      r_dm_we     <= 1'b0;
      r_dm_addr   <= 32'h0000_0000;
      r_dm_wdata  <= 32'h0000_0000;
      r_dm_be     <= 4'b0000;
      r_bus_err   <= 1'b0;
      r_misalign  <= 1'b0;
      r_mis_abort <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bus_err  <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_access && w_mis) begin
            r_misalign  <= 1'b1;
            r_mis_abort <= 1'b1;
          end else if (w_access) begin
            r_dm_req    <= 1'b1;
            r_dm_we     <= i_mem_we;
            r_dm_addr   <= {i_mem_addr[31:2], 2'b00};
            r_dm_wdata  <= w_st_data;
            r_dm_be     <= w_be;
            r_mis_abort <= 1'b0;
          end else begin
            r_mis_abort <= 1'b0;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (i_dm_ack) begin
            r_dm_req <= 1'b0;
            r_dm_we  <= 1'b0;
            r_lbuf   <= w_ld_data;
          end else if (w_timeout) begin
            r_dm_req  <= 1'b0;
            r_dm_we   <= 1'b0;
            r_bus_err <= 1'b1;
            r_lbuf    <= 32'h0000_0000;
          end else begin
            r_dm_req <= r_dm_req;
          end
        end
        DONE: begin
          r_cnt       <= '0;
          r_mis_abort <= 1'b0;
        end
        default: begin
          r_cnt    <= '0;
          r_dm_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_dm_req   = r_dm_req;
  assign o_dm_we    = r_dm_we;
  assign o_dm_addr  = r_dm_addr;
  assign o_dm_wdata = r_dm_wdata;
  assign o_dm_be    = r_dm_be;
  assign o_bus_err  = r_bus_err;
  assign o_misalign = r_misalign;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus pushes expected bus requests and
// retire results into queues; negedge monitors pop and compare.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_mem_addr = 32'h0;
  logic [31:0] i_mem_data = 32'h0;
  logic        i_mem_we = 1'b0;
  logic        i_mem_rd = 1'b0;
  logic [2:0]  i_mem_size = 3'b000;
  logic        o_stall, o_dm_req, o_dm_we;
  logic [31:0] o_dm_addr, o_dm_wdata;
  logic [3:0]  o_dm_be;
  logic [31:0] i_dm_rdata = 32'h0;
  logic        i_dm_ack = 1'b0;
  logic [31:0] o_mem_result;
  logic        o_bus_err, o_misalign;

  logic        drv_valid = 1'b0;
  int          checks = 0;
  int          failures = 0;

  typedef struct packed { logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; logic we; } dm_t;
  typedef struct packed { logic [31:0] res; logic err; logic mis; } ret_t;
  dm_t  dm_q[$];
  ret_t ret_q[$];

  mem_access_ctrl #(.TIMEOUT_CYC(4), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mem_addr(i_mem_addr), .i_mem_data(i_mem_data),
    .i_mem_we(i_mem_we), .i_mem_rd(i_mem_rd), .i_mem_size(i_mem_size), .o_stall(o_stall),
    .o_dm_req(o_dm_req), .o_dm_we(o_dm_we), .o_dm_addr(o_dm_addr), .o_dm_wdata(o_dm_wdata),
    .o_dm_be(o_dm_be), .i_dm_rdata(i_dm_rdata), .i_dm_ack(i_dm_ack), .o_mem_result(o_mem_result),
    .o_bus_err(o_bus_err), .o_misalign(o_misalign)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Bus request monitor: every rising dm_req must match the next queued request.
  initial begin
    logic prev_req;
    dm_t  e;
    prev_req = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_dm_req && !prev_req) begin
        if (dm_q.size() == 0) begin
          chk("dm_req_unexpected", {31'b0, o_dm_req}, 32'd0);
        end else begin
          e = dm_q.pop_front();
          chk("dm_addr", o_dm_addr, e.addr);
          chk("dm_wdata", o_dm_wdata, e.wdata);
          chk("dm_be", {28'b0, o_dm_be}, {28'b0, e.be});
          chk("dm_we", {31'b0, o_dm_we}, {31'b0, e.we});
        end
      end
      prev_req = o_dm_req;
    end
  end

  // Retire monitor: each unstalled cycle with an instruction present completes one item.
  initial begin
    ret_t r;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && drv_valid && !o_stall) begin
        if (ret_q.size() == 0) begin
          chk("retire_unexpected", 32'd1, 32'd0);
        end else begin
          r = ret_q.pop_front();
          chk("mem_result", o_mem_result, r.res);
          chk("bus_err", {31'b0, o_bus_err}, {31'b0, r.err});
          chk("misalign", {31'b0, o_misalign}, {31'b0, r.mis});
          chk("dm_req_at_retire", {31'b0, o_dm_req}, 32'd0);
        end
      end
    end
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] d, input logic we, input logic rd,
                       input logic [2:0] sz, input int ack_dly, input logic [31:0] rdat,
                       input logic [31:0] exp_res, input logic exp_err, input logic exp_mis,
                       input int exp_stall, input logic exp_bus, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd);
    dm_t e;
    ret_t r;
    int n;
    if (exp_bus) begin
      e.addr = {a[31:2], 2'b00}; e.wdata = exp_wd; e.be = exp_be; e.we = we;
      dm_q.push_back(e);
    end
    r.res = exp_res; r.err = exp_err; r.mis = exp_mis;
    ret_q.push_back(r);
    i_mem_addr = a; i_mem_data = d; i_mem_we = we; i_mem_rd = rd; i_mem_size = sz;
    drv_valid = 1'b1;
    n = 0;
    #1;
    while (o_stall === 1'b1 && n < 40) begin
      n++;
      @(posedge i_clk); #1;
      i_dm_ack   = (ack_dly > 0 && n == ack_dly) ? 1'b1 : 1'b0;
      i_dm_rdata = rdat;
    end
    i_dm_ack = 1'b0;
    chk("stall_cycles", 32'(n), 32'(exp_stall));
    @(posedge i_clk); #1;
  endtask

  task automatic go_idle();
    drv_valid = 1'b0; i_mem_rd = 1'b0; i_mem_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    dm_t e;
    i_mem_addr = 32'h0000_1234;
    #12;
    chk("rst_dm_req", {31'b0, o_dm_req}, 32'd0);
    chk("rst_dm_we", {31'b0, o_dm_we}, 32'd0);
    chk("rst_dm_addr", o_dm_addr, 32'd0);
    chk("rst_dm_wdata", o_dm_wdata, 32'd0);
    chk("rst_dm_be", {28'b0, o_dm_be}, 32'd0);
    chk("rst_bus_err", {31'b0, o_bus_err}, 32'd0);
    chk("rst_misalign", {31'b0, o_misalign}, 32'd0);
    chk("rst_stall", {31'b0, o_stall}, 32'd0);
    chk("rst_passthru", o_mem_result, 32'h0000_1234);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // a, d, we, rd, size, ack_dly, rdata, exp_res, err, mis, stall, bus, be, wdata
    do_op(32'h0000_1234, 32'h0, 1'b0, 1'b0, SZ_W, 0, 32'h0, 32'h0000_1234, 1'b0, 1'b0, 0, 1'b0, 4'b0000, 32'h0);
    do_op(32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 1'b0, SZ_W, 2, 32'h0, 32'h0000_0100, 1'b0, 1'b0, 3, 1'b1, 4'b1111, 32'hDEAD_BEEF);
    do_op(32'h0000_0203, 32'h0, 1'b0, 1'b1, SZ_B, 1, 32'h8011_2233, 32'hFFFF_FF80, 1'b0, 1'b0, 2, 1'b1, 4'b1000, 32'h0);
    do_op(32'h0000_0203, 32'h0, 1'b0, 1'b1, SZ_BU, 1, 32'h8011_2233, 32'h0000_0080, 1'b0, 1'b0, 2, 1'b1, 4'b1000, 32'h0);
    do_op(32'h0000_0006, 32'h0000_ABCD, 1'b1, 1'b0, SZ_H, 1, 32'h0, 32'h0000_0006, 1'b0, 1'b0, 2, 1'b1, 4'b1100, 32'hABCD_ABCD);
    do_op(32'h0000_0002, 32'h0, 1'b0, 1'b1, SZ_H, 3, 32'h8001_7FFF, 32'hFFFF_8001, 1'b0, 1'b0, 4, 1'b1, 4'b1100, 32'h0);
    do_op(32'h0000_0000, 32'h0, 1'b0, 1'b1, SZ_HU, 1, 32'h1234_F00D, 32'h0000_F00D, 1'b0, 1'b0, 2, 1'b1, 4'b0011, 32'h0);
    do_op(32'h0000_0101, 32'h0000_00A5, 1'b1, 1'b0, SZ_B, 1, 32'h0, 32'h0000_0101, 1'b0, 1'b0, 2, 1'b1, 4'b0010, 32'hA5A5_A5A5);
    do_op(32'h0000_0040, 32'h0, 1'b0, 1'b1, SZ_W, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1'b0, 2, 1'b1, 4'b1111, 32'h0);
    do_op(32'h0000_0044, 32'h1122_3344, 1'b1, 1'b1, SZ_W, 1, 32'hFFFF_FFFF, 32'h0000_0044, 1'b0, 1'b0, 2, 1'b1, 4'b1111, 32'h1122_3344);
    do_op(32'h0000_0080, 32'h0, 1'b0, 1'b1, SZ_W, 0, 32'h5555_5555, 32'h0000_0000, 1'b1, 1'b0, 5, 1'b1, 4'b1111, 32'h0);
    do_op(32'h0000_5678, 32'h0, 1'b0, 1'b0, SZ_W, 0, 32'h0, 32'h0000_5678, 1'b0, 1'b0, 0, 1'b0, 4'b0000, 32'h0);
`ifdef MEM_MISALIGN_EXC_EN
    do_op(32'h0000_0102, 32'h0, 1'b0, 1'b1, SZ_W, 1, 32'h0BAD_F00D, 32'h0000_0000, 1'b0, 1'b1, 1, 1'b0, 4'b0000, 32'h0);
`else
    do_op(32'h0000_0102, 32'h0, 1'b0, 1'b1, SZ_W, 1, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 1'b0, 2, 1'b1, 4'b1111, 32'h0);
`endif
    do_op(32'h0000_0010, 32'h0, 1'b0, 1'b0, SZ_W, 0, 32'h0, 32'h0000_0010, 1'b0, 1'b0, 0, 1'b0, 4'b0000, 32'h0);

    // Stray ack while idle must not start anything.
    go_idle();
    i_dm_ack = 1'b1;
    @(posedge i_clk); #1;
    i_dm_ack = 1'b0;
    chk("idle_ack_no_req", {31'b0, o_dm_req}, 32'd0);
    @(posedge i_clk); #1;

    // Reset in the middle of an outstanding load, followed by a late ack.
    e.addr = 32'h0000_0300; e.wdata = 32'h0; e.be = 4'b1111; e.we = 1'b0;
    dm_q.push_back(e);
    i_mem_addr = 32'h0000_0300; i_mem_data = 32'h0; i_mem_size = SZ_W; i_mem_rd = 1'b1;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    chk("busy_req_before_rst", {31'b0, o_dm_req}, 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("rst_mid_busy_req", {31'b0, o_dm_req}, 32'd0);
    i_mem_rd = 1'b0;
    #1;
    chk("rst_mid_busy_stall", {31'b0, o_stall}, 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    i_dm_ack = 1'b1; i_dm_rdata = 32'h7777_7777;
    @(posedge i_clk); #1;
    i_dm_ack = 1'b0;
    chk("late_ack_req", {31'b0, o_dm_req}, 32'd0);
    chk("late_ack_stall", {31'b0, o_stall}, 32'd0);
    chk("late_ack_result", o_mem_result, 32'h0000_0300);
    chk("late_ack_bus_err", {31'b0, o_bus_err}, 32'd0);
    do_op(32'h0000_0008, 32'h0102_0304, 1'b1, 1'b0, SZ_W, 1, 32'h0, 32'h0000_0008, 1'b0, 1'b0, 2, 1'b1, 4'b1111, 32'h0102_0304);

    go_idle();
    repeat (3) @(posedge i_clk);
    #1;
    chk("dm_q_drained", 32'(dm_q.size()), 32'd0);
    chk("ret_q_drained", 32'(ret_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
